// File: rtl/adc_channel_scheduler.sv
// Scans up to eight analog inputs through one shared SAR converter: per channel it settles the mux
// with the converter held in reset, runs a fixed conversion window, then latches the 8-bit result.
module adc_channel_scheduler #(
  parameter int unsigned NUM_CH        = 6,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CONV_CYCLES   = 600
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  FRAME_REQ,
  input  logic [NUM_CH-1:0]     CH_MASK,
  input  logic [7:0]            ADC_DATA,
  output logic                  ADC_RESET_N,
  output logic [2:0]            MUX_SEL,
  output logic [8*NUM_CH-1:0]   CH_DATA,
  output logic [NUM_CH-1:0]     CH_VALID,
  output logic                  SAMPLE_STROBE,
  output logic [2:0]            SAMPLE_CH,
  output logic                  FRAME_DONE,
  output logic                  BUSY
);

  typedef enum logic [1:0] {IDLE, SELECT, CONVERT, ADVANCE} state_e;

  localparam logic [11:0] SETTLE_LOAD = 12'(SETTLE_CYCLES - 1);
  localparam logic [11:0] CONV_LOAD   = 12'(CONV_CYCLES - 1);

  state_e                state_q, state_d;
  logic [11:0]           cnt_q, cnt_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [2:0]            cur_q, cur_d;
  logic                  pend_q, pend_d;
  logic                  adc_rst_n_q, adc_rst_n_d;
  logic [2:0]            mux_q, mux_d;
  logic [8*NUM_CH-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]     valid_q, valid_d;
  logic                  strobe_q, strobe_d;
  logic [2:0]            sch_q, sch_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  start;
  logic [NUM_CH-1:0]     above;

  function automatic logic [2:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [NUM_CH-1:0] t;
    lowest_ch = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      t = m >> (i - 1);
      if (t[0]) lowest_ch = 3'(i - 1);
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    cur_d       = cur_q;
    pend_d      = pend_q | (FRAME_REQ & busy_q);
    adc_rst_n_d = adc_rst_n_q;
    mux_d       = mux_q;
    data_d      = data_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    sch_d       = sch_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    start       = 1'b0;
    // Latched-mask channels strictly above the current one; the shift wraps to zero past the top.
    above       = mask_q & ~((NUM_CH'(2) << cur_q) - NUM_CH'(1));

    case (state_q)
      IDLE: begin
        adc_rst_n_d = 1'b0;
        if ((ENABLE || FRAME_REQ || pend_q) && (CH_MASK != '0)) start = 1'b1;
        else pend_d = 1'b0;
      end
      SELECT: begin
        if (cnt_q == '0) begin
          state_d     = CONVERT;
          cnt_d       = CONV_LOAD;
          adc_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      CONVERT: begin
        if (cnt_q == '0) begin
          for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (cur_q == 3'(ch)) begin
              data_d[8*ch +: 8] = ADC_DATA;
              valid_d[ch]       = 1'b1;
            end
          end
          strobe_d    = 1'b1;
          sch_d       = cur_q;
          done_d      = (above == '0);
          state_d     = ADVANCE;
          adc_rst_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      ADVANCE: begin
        if (above != '0) begin
          state_d = SELECT;
          cur_d   = lowest_ch(above);
          mux_d   = lowest_ch(above);
          cnt_d   = SETTLE_LOAD;
        end else if ((ENABLE || pend_q) && (CH_MASK != '0)) begin
          start = 1'b1;
        end else begin
          // A request arriving in this final cycle is carried into IDLE rather than lost.
          state_d = IDLE;
          busy_d  = 1'b0;
          pend_d  = FRAME_REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d     = SELECT;
      mask_d      = CH_MASK;
      cur_d       = lowest_ch(CH_MASK);
      mux_d       = lowest_ch(CH_MASK);
      cnt_d       = SETTLE_LOAD;
      busy_d      = 1'b1;
      pend_d      = 1'b0;
      adc_rst_n_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      cur_q       <= '0;
      pend_q      <= 1'b0;
      adc_rst_n_q <= 1'b0;
      mux_q       <= '0;
      data_q      <= '0;
      valid_q     <= '0;
      strobe_q    <= 1'b0;
      sch_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      adc_rst_n_q <= adc_rst_n_d;
      mux_q       <= mux_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      sch_q       <= sch_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign ADC_RESET_N   = adc_rst_n_q;
  assign MUX_SEL       = mux_q;
  assign CH_DATA       = data_q;
  assign CH_VALID      = valid_q;
  assign SAMPLE_STROBE = strobe_q;
  assign SAMPLE_CH     = sch_q;
  assign FRAME_DONE    = done_q;
  assign BUSY          = busy_q;

endmodule

// File: doc/adc_channel_scheduler.md
# adc_channel_scheduler

Time-multiplexes the single SAR comparator/RC converter across up to eight analog inputs (stick X/Y, C-stick X/Y, L/R triggers) through an external analog mux. For each enabled channel it holds the converter in reset while driving the mux and letting the input settle, releases it for a fixed conversion window, then captures the converter's 8-bit output into a per-channel result register. It sits between the converter and the controller report logic, which reads the packed result bank.

## Interface
- NUM_CH, 6: channels scanned, legal 1..8.
- SETTLE_CYCLES, 16: cycles the converter is held in reset with the mux stable, legal 1..4095.
- CONV_CYCLES, 600: cycles from converter reset release to result capture, legal 1..4095. Must exceed one full converter discharge-plus-8-bit conversion.
- CLK  in  1  system clock, 40 MHz.
- RESET  in  1  asynchronous, active-low reset.
- ENABLE  in  1  continuous scanning while high.
- FRAME_REQ  in  1  single-cycle pulse requesting one scan frame.
- CH_MASK  in  NUM_CH  bit i=1 includes channel i in the frame.
- ADC_DATA  in  8  converter digital output.
- ADC_RESET_N  out  1  drives the converter's active-low reset.
- MUX_SEL  out  3  analog mux channel select.
- CH_DATA  out  8*NUM_CH  result bank; channel i at [8i+7:8i].
- CH_VALID  out  NUM_CH  sticky; bit i set on the first capture of channel i.
- SAMPLE_STROBE  out  1  one-cycle pulse when a result is written.
- SAMPLE_CH  out  3  channel written; valid with SAMPLE_STROBE, holds its value otherwise.
- FRAME_DONE  out  1  one-cycle pulse when the last masked channel of a frame is written.
- BUSY  out  1  high from SELECT through the ADVANCE that ends a frame.

## Operation
- All outputs are registered. Reset values: ADC_RESET_N=0, MUX_SEL=0, CH_DATA=0, CH_VALID=0, SAMPLE_STROBE=0, SAMPLE_CH=0, FRAME_DONE=0, BUSY=0. State resets to IDLE and the pending flag to 0.
- States:
  - IDLE: ADC_RESET_N=0.
  - SELECT: ADC_RESET_N=0, MUX_SEL=current channel.
  - CONVERT: ADC_RESET_N=1.
  - ADVANCE: ADC_RESET_N=0.
- IDLE -> SELECT when (ENABLE or FRAME_REQ or pending) and CH_MASK is nonzero.
  - CH_MASK is latched at frame start. The current channel is the lowest set bit. Pending is cleared.
  - A zero mask stays in IDLE, produces no FRAME_DONE, and drops a FRAME_REQ.
- SELECT -> CONVERT after exactly SETTLE_CYCLES cycles.
- CONVERT -> ADVANCE after exactly CONV_CYCLES cycles.
  - On the edge leaving CONVERT: ADC_DATA is written to CH_DATA[current], CH_VALID[current] is set, SAMPLE_CH=current, SAMPLE_STROBE=1.
- ADVANCE (1 cycle):
  - If the latched mask has a higher set bit, go to SELECT on that channel.
  - Otherwise pulse FRAME_DONE (same cycle as the last SAMPLE_STROBE). Then, if ENABLE or pending, start a new frame (re-latch CH_MASK; same IDLE rules, no IDLE cycle). Else go to IDLE.
- Counters: one shared 12-bit down-counter, loaded with N-1 on state entry; the transition fires at 0.
- FRAME_REQ while BUSY sets pending; multiple requests collapse to one extra frame. FRAME_REQ with ENABLE high has no extra effect.
- ENABLE falling mid-frame: the frame completes, then the block goes to IDLE.
- CH_MASK changes mid-frame are ignored until the next frame start.
- Asynchronous reset mid-conversion: the immediate return to reset values clears CH_DATA and CH_VALID and discards the partial conversion.

## Timing
- Per-channel slot: SETTLE_CYCLES + CONV_CYCLES + 1 cycles.
- Frame length: popcount(mask) × slot.
- Start latency: ENABLE or FRAME_REQ sampled high in IDLE on edge k gives SELECT (ADC_RESET_N=0, MUX_SEL valid) from edge k.
- ADC_RESET_N rises on the edge after SETTLE_CYCLES SELECT cycles. The first SAMPLE_STROBE is visible SETTLE_CYCLES + CONV_CYCLES cycles after entering SELECT.
- MUX_SEL changes only on entry to SELECT, always while ADC_RESET_N=0.
- CH_DATA for a channel changes only on its SAMPLE_STROBE cycle. Other channels hold their values.

## Test plan
- Reset/idle: release RESET with ENABLE=0, FRAME_REQ=0, wait 100 cycles -> all outputs at reset values, ADC_RESET_N=0, BUSY=0, no strobes.
- Continuous scan (SETTLE=4, CONV=20, mask 6'b111111, ADC model returns 8'hA0+MUX_SEL):
  - Strobes every 25 cycles, channel order 0..5.
  - CH_DATA = A5 A4 A3 A2 A1 A0 (channels 5..0).
  - FRAME_DONE coincides with the channel-5 strobe.
  - The next frame's SELECT begins the following cycle.
- Sparse mask 6'b100100, single FRAME_REQ:
  - Strobes only for channels 2 then 5, 50 cycles total, then FRAME_DONE.
  - Then IDLE, BUSY=0.
  - CH_VALID=6'b100100, other CH_DATA bytes remain 0.
- Request during busy: three FRAME_REQ pulses mid-frame -> exactly one extra frame, then IDLE. Mask changed mid-frame takes effect only in the extra frame.
- Zero mask: FRAME_REQ with CH_MASK=0 -> no state change, no FRAME_DONE, BUSY stays 0.
- Async reset mid-CONVERT (channel 3, cycle 10):
  - All outputs return to reset values immediately, with no strobe.
  - After release with ENABLE=1, scanning restarts at the lowest masked channel.
